// File: rtl/clk_divider_50m_pkg.sv
// Project clock constants for the 50 MHz digital-clock divider.
// Each divider half-period is derived from the board clock frequency.
package clk_divider_50m_pkg;

    localparam int unsigned CLK_IN_HZ = 32'd50_000_000;
    localparam int unsigned CNT_W_DEF = 32'd25;

    function automatic int unsigned half_for(input int unsigned freq_hz);
        return CLK_IN_HZ / (32'd2 * freq_hz);
    endfunction

    localparam int unsigned HALF_500HZ_DEF = half_for(32'd500);
    localparam int unsigned HALF_4HZ_DEF   = half_for(32'd4);
    localparam int unsigned HALF_1HZ_DEF   = half_for(32'd1);

endpackage

// File: rtl/clk_divider_50m_if.sv
// Bundle of the three derived square-wave clocks.
// The divider drives it through master; consumers read it through slave.
interface clk_divider_50m_if;
    logic clk_out_500Hz;
    logic clk_out_4Hz;
    logic clk_out_1Hz;

    modport master (output clk_out_500Hz, output clk_out_4Hz, output clk_out_1Hz);
    modport slave  (input  clk_out_500Hz, input  clk_out_4Hz, input  clk_out_1Hz);
endinterface

// File: rtl/clk_divider_50m_toggle.sv
// One divider stage: a counter that wraps at HALF-1 and a toggle flop,
// giving a 50% duty square wave of period 2*HALF input cycles.
module clk_div_toggle #(
    parameter int unsigned HALF  = 32'd50_000,
    parameter int unsigned CNT_W = 32'd25
) (
    input  logic clk,
    input  logic rst,
    output logic clk_out
);

    if ((HALF < 32'd1) || ((64'd1 << CNT_W) <= 64'(HALF))) begin : g_param_check
        $error("clk_div_toggle: HALF must be >= 1 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 32'd1);

    logic [CNT_W-1:0] cnt;

    // Count HALF cycles, then flip the output and restart from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt     <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_divider_50m.sv
// Three parallel dividers producing 500 Hz, 4 Hz and 1 Hz from the 50 MHz board clock.
// rst_n is a synchronous, active-high reset; the name is historical.
module clk_divider_50m
    import clk_divider_50m_pkg::*;
#(
    parameter int unsigned HALF_500HZ = HALF_500HZ_DEF,
    parameter int unsigned HALF_4HZ   = HALF_4HZ_DEF,
    parameter int unsigned HALF_1HZ   = HALF_1HZ_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic               clk_in_50M,
    input  logic               rst_n,
    clk_divider_50m_if.master  outs
);

    clk_div_toggle #(.HALF(HALF_500HZ), .CNT_W(CNT_W)) u_div_500hz (
        .clk     (clk_in_50M),
        .rst     (rst_n),
        .clk_out (outs.clk_out_500Hz)
    );

    clk_div_toggle #(.HALF(HALF_4HZ), .CNT_W(CNT_W)) u_div_4hz (
        .clk     (clk_in_50M),
        .rst     (rst_n),
        .clk_out (outs.clk_out_4Hz)
    );

    clk_div_toggle #(.HALF(HALF_1HZ), .CNT_W(CNT_W)) u_div_1hz (
        .clk     (clk_in_50M),
        .rst     (rst_n),
        .clk_out (outs.clk_out_1Hz)
    );

endmodule

// File: tb/tb_clk_divider_50m.sv
// Bench for clk_divider_50m with shortened half-periods (5/20/40): each output
// after n released edges is floor(n/HALF) mod 2; also run lengths and key edges.
module tb_clk_divider_50m;

    localparam int H500 = 5;
    localparam int H4   = 20;
    localparam int H1   = 40;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    clk_divider_50m_if dut_if ();

    clk_divider_50m #(
        .HALF_500HZ (32'(H500)),
        .HALF_4HZ   (32'(H4)),
        .HALF_1HZ   (32'(H1)),
        .CNT_W      (32'd25)
    ) dut (
        .clk_in_50M (clk),
        .rst_n      (rst),
        .outs       (dut_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Model state: edges since release, previous samples, run lengths.
    int   n_rel;
    int   halfs [3];
    logic prev  [3];
    int   run   [3];
    bit   run_ok[3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d after release)", tag, got, exp, n_rel);
        end
    endtask

    function automatic logic dut_out(input int i);
        case (i)
            0:       return dut_if.clk_out_500Hz;
            1:       return dut_if.clk_out_4Hz;
            default: return dut_if.clk_out_1Hz;
        endcase
    endfunction

    task automatic step(input logic r);
        logic cur [3];
        string names [3];
        names = '{"out_500", "out_4", "out_1"};
        rst = r;
        @(posedge clk);
        #1;
        if (r) n_rel = 0;
        else   n_rel++;
        for (int i = 0; i < 3; i++) begin
            cur[i] = dut_out(i);
            check_val(names[i], 32'(cur[i]), 32'((n_rel / halfs[i]) % 2));
            if (r) begin
                run_ok[i] = 1'b0;
                run[i]    = 0;
            end else if (cur[i] == prev[i]) begin
                run[i]++;
            end else begin
                if (run_ok[i]) check_val({names[i], "_runlen"}, 32'(run[i]), 32'(halfs[i]));
                run_ok[i] = 1'b1;
                run[i]    = 1;
            end
        end
        if (!r && n_rel == H1) begin
            check_val("coinc_1hz_rise",  {30'd0, prev[2], cur[2]}, 32'b01);
            check_val("coinc_4hz_fall",  {30'd0, prev[1], cur[1]}, 32'b10);
            check_val("coinc_500_toggle", 32'(prev[0] ^ cur[0]), 32'd1);
        end
        if (!r && n_rel == H500)
            check_val("first_500_rise", {30'd0, prev[0], cur[0]}, 32'b01);
        for (int i = 0; i < 3; i++) prev[i] = cur[i];
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n_rel    = 0;
        halfs    = '{H500, H4, H1};
        for (int i = 0; i < 3; i++) begin
            prev[i]   = 1'b0;
            run[i]    = 0;
            run_ok[i] = 1'b0;
        end
        rst = 1'b1;

        // Reset hold: outputs stay low.
        for (int k = 0; k < 5; k++) step(1'b1);

        // Release and run to edge 26, where 500 Hz and 4 Hz are both high.
        for (int k = 0; k < 26; k++) step(1'b0);
        check_val("pre_reset_500_high", 32'(dut_if.clk_out_500Hz), 32'd1);
        check_val("pre_reset_4_high",   32'(dut_if.clk_out_4Hz),   32'd1);

        // Mid-run reset on edge 27.
        step(1'b1);
        check_val("mid_reset_all_low",
                  {29'd0, dut_if.clk_out_1Hz, dut_if.clk_out_4Hz, dut_if.clk_out_500Hz}, 32'd0);
        step(1'b1);

        // Ten full 1 Hz periods with no reset: duty and period on every output.
        for (int k = 0; k < 10 * 2 * H1 + 5; k++) step(1'b0);

        // Random reset pulses of random length at random times.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                int len;
                len = int'($urandom_range(1, 6));
                for (int j = 0; j < len; j++) step(1'b1);
            end else begin
                step(1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
